// File: rtl/regression_evaluator.sv
// regression_evaluator: per-sample yhat = B0 + B1*x and err = y - yhat.
// Define REGEVAL_SSE_EN to build the saturating sum-of-squared-errors accumulator.
module regression_evaluator #(
    parameter int W    = 20,
    parameter int FRAC = 10,
    parameter int NW   = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] n,
    input  logic [W-1:0]  B0,
    input  logic [W-1:0]  B1,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  yhat,
    output logic [W-1:0]  err,
    output logic          busy,
    output logic          done,
    output logic [47:0]   sse
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nx;

    logic [W-1:0]          b0_q, b1_q;
    logic [NW-1:0]         rem;
    logic                  xfer;
    logic                  launch;
    logic signed [2*W-1:0] prod;
    logic [W-1:0]          yhat_d, err_d;

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign launch   = (state == IDLE) && start;
    assign in_ready = busy && (rem != '0) && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;

    assign prod   = (2*W)'($signed(b1_q)) * (2*W)'($signed(x));
    assign yhat_d = W'(prod >>> FRAC) + b0_q;
    assign err_d  = y - yhat_d;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = (n == '0) ? DONE : RUN;
            RUN: begin
                // finish only once the last result has left the output register
                if (rem == '0 && (!out_valid || out_ready))
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            b0_q      <= '0;
            b1_q      <= '0;
            rem       <= '0;
            out_valid <= 1'b0;
            yhat      <= '0;
            err       <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                b0_q <= B0;
                b1_q <= B1;
                rem  <= n;
            end else if (xfer) begin
                rem <= rem - NW'(1);
            end
            if (xfer) begin
                out_valid <= 1'b1;
                yhat      <= yhat_d;
                err       <= err_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef REGEVAL_SSE_EN
    logic signed [2*W-1:0] e_ext;
    logic [2*W-1:0]        sq;
    logic [48:0]           acc;

    assign e_ext = (2*W)'($signed(err_d));
    assign sq    = e_ext * e_ext;
    assign acc   = {1'b0, sse} + 49'(sq);

    always_ff @(posedge clk) begin
        if (rst)
            sse <= '0;
        else if (launch)
            sse <= '0;
        else if (xfer)
            sse <= acc[48] ? {48{1'b1}} : acc[47:0];
    end
`else
    assign sse = '0;
`endif

endmodule

// File: tb/tb_regression_evaluator.sv
// Scoreboard bench for regression_evaluator: randomized runs checked
// against an arithmetic reference model, plus the directed corner cases.
module tb_regression_evaluator;
    localparam int W    = 20;
    localparam int FRAC = 10;
    localparam int NW   = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NW-1:0] n;
    logic [W-1:0]  B0, B1;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  x, y;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  yhat, err;
    logic          busy, done;
    logic [47:0]   sse;

    regression_evaluator #(.W(W), .FRAC(FRAC), .NW(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .n(n),
        .B0(B0), .B1(B1),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready),
        .yhat(yhat), .err(err),
        .busy(busy), .done(done), .sse(sse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] yh;
        logic [W-1:0] er;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    bit busy_seen, ov_seen;
    int rmode = 0;
    bit stalled = 0;
    int stall_left = 0;
    bit use_const = 0;

    logic [W-1:0] xs[64], ys[64], cyh[64], cer[64];
    logic [W-1:0] m_b0, m_b1;
    longint exp_sse;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // floor(B1*x / 2^FRAC) + B0, wrapped to W bits
    function automatic exp_t model(input logic [W-1:0] b0v, b1v, xv, yv);
        exp_t r;
        longint p, md, q, s;
        p  = longint'($signed(b1v)) * longint'($signed(xv));
        md = ((p % 1024) + 1024) % 1024;
        q  = (p - md) / 1024;
        s  = q + longint'(b0v);
        r.yh = s[W-1:0];
        s  = longint'(yv) - longint'(r.yh);
        r.er = s[W-1:0];
        return r;
    endfunction

    task automatic push(input int idx);
        exp_t e;
        longint ev, cap;
        e = model(m_b0, m_b1, xs[idx], ys[idx]);
        if (use_const) begin
            e.yh = cyh[idx];
            e.er = cer[idx];
        end
        sb.push_back(e);
        ev  = longint'($signed(e.er));
        cap = 64'h0000_FFFF_FFFF_FFFF;
        exp_sse = exp_sse + ev * ev;
        if (exp_sse > cap) exp_sse = cap;
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (!stalled && out_valid) begin
                        stalled = 1;
                        stall_left = 3;
                    end
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b0;
            endcase
        end
    end

    // monitor: pops the scoreboard on each output transfer
    initial begin
        bit acc, hold;
        logic [W-1:0] hy, he;
        exp_t e;
        acc = 0;
        hold = 0;
        hy = '0;
        he = '0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                acc = 0;
                hold = 0;
            end else begin
                if (acc) check("latency_out_valid", out_valid, 1);
                if (hold) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_yhat", yhat, hy);
                    check("stall_err", err, he);
                end
                if (out_valid && !out_ready)
                    check("stall_in_ready", in_ready, 0);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("yhat", yhat, e.yh);
                        check("err", err, e.er);
                    end
                end
                if (done) done_cnt++;
                if (busy) busy_seen = 1;
                if (out_valid) ov_seen = 1;
                acc  = in_valid && in_ready;
                hold = out_valid && !out_ready;
                hy   = yhat;
                he   = err;
            end
        end
    end

    task automatic run_job(input int nn, input logic [W-1:0] b0v, b1v,
                           input bit junk, input bit gaps);
        int idx, cyc, d0;
        idx = 0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        n  = NW'(nn);
        B0 = b0v;
        B1 = b1v;
        m_b0 = b0v;
        m_b1 = b1v;
        exp_sse = 0;
        busy_seen = 0;
        ov_seen = 0;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        n  = NW'($urandom);
        B0 = W'($urandom);
        B1 = W'($urandom);
        if (nn == 0) begin
            #4;
            check("n0_done_next", done, 1);
            @(negedge clk);
        end
        while (idx < nn && cyc < 500) begin
            start = junk && (idx == 1);
            if (start) n = NW'($urandom_range(1, 20));
            in_valid = !gaps || ($urandom_range(0, 3) != 0);
            x = xs[idx];
            y = ys[idx];
            #4;
            if (in_valid && in_ready) begin
                push(idx);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        while (done_cnt == d0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", done_cnt != d0, 1);
        repeat (3) @(negedge clk);
        #4;
        check("done_once", done_cnt - d0, 1);
        check("sb_drained", sb.size(), 0);
        check("busy_after", busy, 0);
        check("busy_seen", busy_seen, nn != 0);
        check("out_seen", ov_seen, nn != 0);
`ifdef REGEVAL_SSE_EN
        check("sse", sse, exp_sse);
`else
        check("sse_zero", sse, 0);
`endif
        sb.delete();
    endtask

    initial begin
        int d;
        rst = 1'b1;
        start = 1'b0;
        n = '0;
        B0 = '0;
        B1 = '0;
        in_valid = 1'b0;
        x = '0;
        y = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_yhat", yhat, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sse", sse, 0);
        @(negedge clk);
        rst = 1'b0;

        rmode = 0;
        use_const = 1;
        xs[0] = 20'h00C00; ys[0] = 20'h01E00;
        cyh[0] = 20'h01C00; cer[0] = 20'h00200;
        run_job(1, 20'h00400, 20'h00800, 0, 0);
`ifdef REGEVAL_SSE_EN
        check("sse_vec1", sse, 48'h40000);
`endif
        xs[0] = 20'h00800; ys[0] = 20'h00000;
        cyh[0] = 20'hFF800; cer[0] = 20'h00800;
        run_job(1, 20'h00000, 20'hFFC00, 0, 0);
        xs[0] = 20'h00400; ys[0] = 20'h00000;
        cyh[0] = 20'h80000; cer[0] = 20'h80000;
        run_job(1, 20'h7FC00, 20'h00400, 0, 0);
        use_const = 0;

        rmode = 2;
        stalled = 0;
        for (int i = 0; i < 4; i++) begin
            xs[i] = W'($urandom);
            ys[i] = W'($urandom);
        end
        run_job(4, W'($urandom), W'($urandom), 0, 0);

        rmode = 0;
        run_job(0, W'($urandom), W'($urandom), 0, 0);

        rmode = 3;
        @(negedge clk);
        start = 1'b1;
        n = NW'(4);
        B0 = 20'h00400;
        B1 = 20'h00400;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        x = 20'h00400;
        y = 20'h00000;
        #4;
        check("rmid_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #4;
        check("rmid_valid", out_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        d = done_cnt;
        @(posedge clk);
        #1;
        check("rmid_out_valid", out_valid, 0);
        check("rmid_yhat", yhat, 0);
        check("rmid_err", err, 0);
        check("rmid_busy", busy, 0);
        check("rmid_in_ready", in_ready, 0);
        check("rmid_done", done, 0);
        check("rmid_sse", sse, 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        check("rmid_no_done", done_cnt - d, 0);

        rmode = 1;
        for (int j = 0; j < 20; j++) begin
            int nn;
            nn = $urandom_range(1, 12);
            for (int i = 0; i < nn; i++) begin
                xs[i] = W'($urandom);
                ys[i] = W'($urandom);
            end
            run_job(nn, W'($urandom), W'($urandom), 1, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regression_evaluator.md
# regression_evaluator

Consumes the linear-regression coefficients B0/B1 produced by the coefficient unit and evaluates them against a stream of (x, y) samples. For each accepted sample it emits the prediction yhat = B0 + B1·x and the residual err = y − yhat, and optionally accumulates the sum of squared errors. It sits downstream of the coefficient unit as the reader of its B0/B1 outputs, using the same 20-bit fixed-point sample format.

## Interface
- W, 20, sample/coefficient width (two's complement)
- FRAC, 10, fraction bits (Q10.10 at defaults)
- NW, 10, sample-count width
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; synchronous, active-high
- start  input  1  one-cycle pulse; latches B0, B1, n and begins a run
- n  input  NW  number of samples in the run
- B0  input  W  intercept coefficient
- B1  input  W  slope coefficient
- in_valid  input  1  x/y valid
- in_ready  output  1  block accepts x/y this cycle
- x  input  W  sample x
- y  input  W  sample y
- out_valid  output  1  yhat/err valid
- out_ready  input  1  consumer takes yhat/err this cycle
- yhat  output  W  prediction
- err  output  W  residual
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse at end of run
- sse  output  48  sum of squared errors, Q28.20 unsigned (see Configuration)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 → latch B0, B1, n into internal registers; clear remaining-count ← n, sse ← 0; go to RUN. If n=0, go directly to DONE instead.
- RUN: in_ready = (remaining≠0) && (!out_valid || out_ready). A sample transfers when in_valid && in_ready; remaining decrements by 1.
- RUN → DONE when remaining=0 and output register is empty (out_valid=0, or drained by out_ready this cycle).
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE. B0/B1/n inputs are don't-care after latch.
- Arithmetic: product = B1·x, full 2W signed. yhat = (product >>> FRAC)[W-1:0] + B0, modulo 2^W (arithmetic shift, truncation toward −∞, wrap-around, no saturation). err = y − yhat, modulo 2^W.
- Output register holds yhat/err stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=0, out_valid=0, yhat=0, err=0, busy=0, done=0, sse=0, state IDLE, remaining=0.
- Latency: sample accepted on edge k → out_valid=1 with its yhat/err after edge k (visible in cycle k+1).
- Throughput: one sample per cycle when out_ready held high.
- Simultaneous out_ready and new input transfer in same cycle: old result leaves, new result loads; no bubble.
- Reset mid-run: on the next edge all state returns to reset values; pending output is discarded, no done pulse.
- done asserts the cycle after the last result is taken (or the cycle after start when n=0).

## Configuration
- REGEVAL_SSE_EN defined: on each output load, err² (2W bits, unsigned) is added to sse; sse saturates at 48'hFFFF_FFFF_FFFF. sse is cleared on start and held stable after DONE until the next start.
- REGEVAL_SSE_EN undefined: no squarer/accumulator; sse tied to 0.

## Test plan
- B0=0x00400 (1.0), B1=0x00800 (2.0), n=1, x=0x00C00 (3.0), y=0x01E00 (7.5) → yhat=0x01C00, err=0x00200 one cycle after accept; done pulses; with REGEVAL_SSE_EN sse=0x40000.
- B0=0, B1=0xFFC00 (−1.0), x=0x00800, y=0 → yhat=0xFF800 (−2.0), err=0x00800.
- B0=0x7FC00 (511.0), B1=0x00400, x=0x00400, y=0 → yhat wraps to 0x80000, err=0x80000.
- n=4, in_valid constant, out_ready low for 3 cycles after first result → yhat/err stable, in_ready=0 during stall; all 4 results delivered in order, done once.
- n=0 start → done pulse the next cycle, no out_valid, busy never high; start pulsed during RUN is ignored.
- rst asserted mid-run with out_valid=1 → next cycle all outputs 0, IDLE; fresh start runs normally.
